// File: rtl/ccff_pkg.sv
// Shared types and defaults for the configuration-chain bitstream loader.
package ccff_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  function automatic int unsigned BITCNT_W(input int unsigned word_w);
    return $clog2(word_w) + 1;
  endfunction

endpackage

// File: rtl/ccff_readback_packer.sv
// Packs ccff_tail bits LSB first into words and presents them on a valid/ready
// port; asserts block when the next shift must wait for the consumer.
module ccff_readback_packer
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture,
  input  logic              tail,
  input  logic              last,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              block
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] word_nxt;
  logic [IDX_W-1:0]  idx;
  logic              complete;

  always_comb begin
    word_nxt      = acc;
    word_nxt[idx] = tail;
  end

  assign complete = capture && (last || (idx == IDX_W'(WORD_W - 1)));
  // Stall whenever a word is (or is about to be) waiting for the consumer.
  assign block    = (rd_valid && !rd_ready) || complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      idx      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      idx      <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      if (capture) begin
        if (complete) begin
          rd_data  <= word_nxt;
          rd_valid <= 1'b1;
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc <= word_nxt;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises host bitstream words onto a tile column's ccff chain and gates prog_clk.
// Define CCFF_READBACK_EN to capture ccff_tail into readback words.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
);

  localparam int unsigned BCW = BITCNT_W(WORD_W);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [BCW-1:0]    bitcnt;
  logic [WORD_W-2:0] shreg;
  logic              abort_busy, handshake, shift_now, last_bit, word_end;
  logic              en_nxt, rb_block;

  assign abort_busy = cfg_abort && (state != IDLE);
  assign wr_ready   = (state == FETCH) && !cfg_abort;
  assign handshake  = wr_ready && wr_valid;
  assign shift_now  = (state == SHIFT) && prog_clk_en && !cfg_abort;
  assign last_bit   = (remaining == LEN_W'(1));
  assign word_end   = (bitcnt == BCW'(WORD_W - 1));
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = (cfg_len != '0) ? FETCH : DONE;
      FETCH:   if (handshake) state_nxt = SHIFT;
      SHIFT: begin
        if (shift_now) begin
          if (last_bit)      state_nxt = DONE;
          else if (word_end) state_nxt = FETCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_busy) state_nxt = IDLE;
    // Enable is decided a cycle ahead so the gate sees a registered signal.
    en_nxt = (state_nxt == SHIFT) && !rb_block;
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // shreg holds the not-yet-presented bits; ccff_head holds the current one.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      remaining   <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
    end else begin
      prog_clk_en <= en_nxt;
      if (abort_busy) begin
        ccff_head <= 1'b0;
        remaining <= '0;
        bitcnt    <= '0;
      end else begin
        if ((state == IDLE) && cfg_start) remaining <= cfg_len;
        if (handshake) begin
          shreg     <= wr_data[WORD_W-1:1];
          ccff_head <= wr_data[0];
          bitcnt    <= '0;
        end else if (shift_now) begin
          shreg     <= shreg >> 1;
          ccff_head <= last_bit ? 1'b0 : shreg[0];
          bitcnt    <= bitcnt + BCW'(1);
          remaining <= remaining - LEN_W'(1);
        end
      end
    end
  end

`ifdef CCFF_READBACK_EN
  ccff_readback_packer #(.WORD_W(WORD_W)) u_packer (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .clear    (abort_busy),
    .capture  (shift_now),
    .tail     (ccff_tail),
    .last     (last_bit),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .block    (rb_block)
  );
`else
  logic unused_rb;
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
  assign rb_block  = 1'b0;
  assign unused_rb = ^{ccff_tail, rd_ready};
`endif

endmodule
